// File: rtl/adc_stream_pkg.sv
// ============================================================================
// Module      : adc_stream_pkg
// Description : Shared sample type and default sizing for the ADC output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_stream_pkg;

    typedef logic signed [31:0] sample_t;

    localparam int DROP_CNT_W_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/stream_fifo_core.sv
// ============================================================================
// Module      : stream_fifo_core
// Description : Synchronous FIFO storage, pointers and fill level; full/empty
//               are derived from the level counter only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo_core #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LVL_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              pop_req_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              pop_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push;
    logic              pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign pop  = pop_req_i & ~empty_o;
    assign push = push_req_i & (~full_o | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;
    assign pop_o     = pop;

endmodule

`default_nettype wire

// File: rtl/adc_output_fifo.sv
// ============================================================================
// Module      : adc_output_fifo
// Description : Non-stalling output buffer for the decimator stream with
//               valid/ready egress, sticky overflow and saturating drop count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_output_fifo
    import adc_stream_pkg::*;
#(
    parameter  int DATA_WIDTH = $bits(sample_t),
    parameter  int DEPTH      = FIFO_DEPTH_DEFAULT,
    parameter  int DROP_CNT_W = DROP_CNT_W_DEFAULT,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    input  logic                  clr_overflow
);

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  drop;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

    stream_fifo_core #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_req_i (s_valid),
        .wr_data_i  (s_data),
        .pop_req_i  (m_ready),
        .rd_data_o  (rd_data),
        .level_o    (level),
        .full_o     (full),
        .empty_o    (empty),
        .pop_o      (pop)
    );

    assign drop = s_valid & full & ~pop;

    // A drop coinciding with a clear restarts the count at one rather than zero.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)
                drop_count_d = DROP_CNT_W'(1);
            else if (drop_count_q != '1)
                drop_count_d = drop_count_q + 1'b1;
        end else if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_valid    = ~empty;
    assign m_data     = m_valid ? rd_data : '0;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_output_fifo.sv
// ============================================================================
// Module      : tb_adc_output_fifo
// Description : Directed vector table plus corner sequences and a DEPTH=4
//               random scoreboard run for adc_output_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_output_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    logic [31:0] s4_data = '0;
    logic        s4_valid = 1'b0;
    logic        m4_ready = 1'b0;
    logic        clr4 = 1'b0;
    logic [31:0] m4_data;
    logic        m4_valid;
    logic [2:0]  level4;
    logic        overflow4;
    logic [3:0]  drop4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_output_fifo #(.DATA_WIDTH(32), .DEPTH(16), .DROP_CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow)
    );

    adc_output_fifo #(.DATA_WIDTH(32), .DEPTH(4), .DROP_CNT_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s4_data),
        .s_valid      (s4_valid),
        .m_data       (m4_data),
        .m_valid      (m4_valid),
        .m_ready      (m4_ready),
        .level        (level4),
        .overflow     (overflow4),
        .drop_count   (drop4),
        .clr_overflow (clr4)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic [4:0]  el;
        logic        eov;
        logic [15:0] edc;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic ev, input logic [31:0] ed,
                             input logic [4:0] el, input logic eov, input logic [15:0] edc);
        chk({nm, ".m_valid"},    32'(m_valid),    32'(ev));
        chk({nm, ".m_data"},     m_data,          ed);
        chk({nm, ".level"},      32'(level),      32'(el));
        chk({nm, ".overflow"},   32'(overflow),   32'(eov));
        chk({nm, ".drop_count"}, 32'(drop_count), 32'(edc));
    endtask

    initial begin
        logic [31:0] q [$];
        logic        mov;
        logic [3:0]  mdrop;
        logic        prev_hold;
        logic [31:0] prev_data;
        logic        sv, mr, cl, mpop, mpush, mdr, mfull;
        logic [31:0] d;

        //              sv  sd            mr  clr ev  ed            el  ov  dc
        tbl[0] = '{1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 5'd1, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 5'd1, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 5'd1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 16'd0};
        tbl[5] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 16'd0};
        tbl[7] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 16'd0};
        tbl[8] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 16'd0};

        // Power-on reset
        repeat (2) cyc();
        chk_state("reset", 1'b0, 32'h0, 5'd0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Table: ordered pass-through and handshake basics
        for (int i = 0; i < 9; i++) begin
            s_valid = tbl[i].sv;
            s_data = tbl[i].sd;
            m_ready = tbl[i].mr;
            clr_overflow = tbl[i].clr;
            cyc();
            chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eov, tbl[i].edc);
        end
        s_valid = 1'b0; m_ready = 1'b0; clr_overflow = 1'b0;

        // Fill past capacity: oldest kept, four drops
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            cyc();
        end
        s_valid = 1'b0;
        chk_state("fill", 1'b1, 32'h0, 5'd16, 1'b1, 16'd4);

        // Full with simultaneous pop accepts the sample
        s_valid = 1'b1; s_data = 32'd100; m_ready = 1'b1;
        cyc();
        chk_state("full_pop", 1'b1, 32'h1, 5'd16, 1'b1, 16'd4);

        // Clear coinciding with a drop
        s_data = 32'd200; m_ready = 1'b0; clr_overflow = 1'b1;
        cyc();
        chk_state("clr_drop", 1'b1, 32'h1, 5'd16, 1'b1, 16'd1);
        s_valid = 1'b0;
        cyc();
        chk_state("clr_alone", 1'b1, 32'h1, 5'd16, 1'b0, 16'd0);
        clr_overflow = 1'b0;

        // Drain: 1..15 then 100
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d", i), m_data, (i == 16) ? 32'd100 : 32'(i));
            cyc();
        end
        m_ready = 1'b0;
        chk_state("drained", 1'b0, 32'h0, 5'd0, 1'b0, 16'd0);

        // Refill, partially drain to level 5, then reset mid-cycle
        for (int i = 0; i < 17; i++) begin
            s_valid = 1'b1; s_data = 32'h1000 + 32'(i);
            cyc();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("redrain%0d", i), m_data, 32'h1000 + 32'(i));
            cyc();
        end
        m_ready = 1'b0;
        chk_state("pre_reset", 1'b1, 32'h100B, 5'd5, 1'b1, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 1'b0, 32'h0, 5'd0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("no_stale%0d", i), 32'(m_valid), 32'h0);
            chk($sformatf("no_stale_data%0d", i), m_data, 32'h0);
        end
        m_ready = 1'b0;

        // Random stress on DEPTH=4, DROP_CNT_W=4 instance
        mov = 1'b0; mdrop = '0; prev_hold = 1'b0; prev_data = '0;
        for (int n = 0; n < 10000; n++) begin
            chk("rnd.m_valid", 32'(m4_valid), 32'(q.size() != 0));
            chk("rnd.m_data", m4_data, (q.size() != 0) ? q[0] : 32'h0);
            chk("rnd.level", 32'(level4), 32'(q.size()));
            chk("rnd.drop_count", 32'(drop4), 32'(mdrop));
            chk("rnd.overflow", 32'(overflow4), 32'(mov));
            if (prev_hold) chk("rnd.hold", m4_data, prev_data);

            sv = ($urandom_range(0, 99) < 60);
            mr = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 299) == 0);
            d  = $urandom;
            s4_valid = sv; m4_ready = mr; clr4 = cl; s4_data = d;

            mfull = (q.size() == 4);
            mpop  = (q.size() != 0) && mr;
            mpush = sv && (!mfull || mpop);
            mdr   = sv && mfull && !mpop;
            prev_hold = (q.size() != 0) && !mr;
            prev_data = (q.size() != 0) ? q[0] : 32'h0;
            if (mpop)  void'(q.pop_front());
            if (mpush) q.push_back(d);
            if (mdr) begin
                mov = 1'b1;
                mdrop = cl ? 4'd1 : ((mdrop == 4'hF) ? 4'hF : mdrop + 4'd1);
            end else if (cl) begin
                mov = 1'b0;
                mdrop = '0;
            end
            cyc();
        end
        s4_valid = 1'b0; m4_ready = 1'b0; clr4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
